// File: rtl/wshb_if.sv
// Wishbone 16-bit bus bundle shared by the VGA reader, the mire writer and
// the SDRAM controller port.
//   master modport : the side that starts cycles (drives cyc/stb/we/adr/...)
//   slave  modport : the side that answers (drives ack/dat_sm)
interface wshb_if #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 16
);
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [ADR_W-1:0]     adr;
    logic [DAT_W-1:0]     dat_ms;
    logic [DAT_W/8-1:0]   sel;
    logic                 ack;
    logic [DAT_W-1:0]     dat_sm;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel,
        input  ack, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel,
        output ack, dat_sm
    );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master / one-slave Wishbone arbiter (wshb_clk domain).
// M0 = VGA frame reader, M1 = mire pattern writer, slave = SDRAM controller.
// A granted master keeps the bus until it drops cyc; on release the bus goes
// straight to a waiting master with no idle cycle. Per-master ack counters
// (wrap-around) are kept for debug.
// Build option: define WSHB_ARB_RR_EN for round-robin tie-break in IDLE;
// left undefined, M0 always wins a simultaneous request.
module wshb_arbiter #(
    parameter int ADR_W = 32,
    parameter int DAT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    wshb_if.slave            m0,
    wshb_if.slave            m1,
    wshb_if.master           s,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] ack_cnt0,
    output logic [CNT_W-1:0] ack_cnt1
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    state_e           state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] ack_cnt0_q, ack_cnt0_d;
    logic [CNT_W-1:0] ack_cnt1_q, ack_cnt1_d;
    state_e           tie_pick_s;

    // Winner when both masters raise cyc together while the bus is idle.
    always_comb begin
`ifdef WSHB_ARB_RR_EN
        if (last_owner_q == OWNER_M0) begin
            tie_pick_s = ST_OWN1;
        end else begin
            tie_pick_s = ST_OWN0;
        end
`else
        tie_pick_s = ST_OWN0;
`endif
    end

    // Ownership FSM: grant on request, hold while cyc, hand over on release.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = tie_pick_s;
                end else if (m0.cyc) begin
                    state_d = ST_OWN0;
                end else if (m1.cyc) begin
                    state_d = ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!m0.cyc) begin
                    last_owner_d = OWNER_M0;
                    state_d      = m1.cyc ? ST_OWN1 : ST_IDLE;
                end else begin
                    state_d = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!m1.cyc) begin
                    last_owner_d = OWNER_M1;
                    state_d      = m0.cyc ? ST_OWN0 : ST_IDLE;
                end else begin
                    state_d = ST_OWN1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Combinational routing of the owner's signals to the slave and of the
    // slave ack back to the owner; an owner that drops cyc is cut off at once.
    always_comb begin
        grant     = 2'b00;
        s.cyc     = 1'b0;
        s.stb     = 1'b0;
        s.we      = 1'b0;
        s.adr     = {ADR_W{1'b0}};
        s.dat_ms  = {DAT_W{1'b0}};
        s.sel     = {(DAT_W/8){1'b0}};
        m0.ack    = 1'b0;
        m1.ack    = 1'b0;
        m0.dat_sm = s.dat_sm;
        m1.dat_sm = s.dat_sm;
        case (state_q)
            ST_OWN0: begin
                grant    = 2'b01;
                s.cyc    = m0.cyc;
                s.stb    = m0.cyc & m0.stb;
                s.we     = m0.cyc & m0.we;
                s.adr    = m0.cyc ? m0.adr : {ADR_W{1'b0}};
                s.dat_ms = m0.cyc ? m0.dat_ms : {DAT_W{1'b0}};
                s.sel    = m0.cyc ? m0.sel : {(DAT_W/8){1'b0}};
                m0.ack   = s.ack & m0.cyc & m0.stb;
            end
            ST_OWN1: begin
                grant    = 2'b10;
                s.cyc    = m1.cyc;
                s.stb    = m1.cyc & m1.stb;
                s.we     = m1.cyc & m1.we;
                s.adr    = m1.cyc ? m1.adr : {ADR_W{1'b0}};
                s.dat_ms = m1.cyc ? m1.dat_ms : {DAT_W{1'b0}};
                s.sel    = m1.cyc ? m1.sel : {(DAT_W/8){1'b0}};
                m1.ack   = s.ack & m1.cyc & m1.stb;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    // Debug ack counters: one count per delivered ack, wrapping naturally.
    always_comb begin
        if (m0.ack) begin
            ack_cnt0_d = ack_cnt0_q + CNT_W'(1);
        end else begin
            ack_cnt0_d = ack_cnt0_q;
        end
        if (m1.ack) begin
            ack_cnt1_d = ack_cnt1_q + CNT_W'(1);
        end else begin
            ack_cnt1_d = ack_cnt1_q;
        end
    end

    // State, last owner and counters; last owner starts at M1 so M0 wins the
    // first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWNER_M1;
            ack_cnt0_q   <= {CNT_W{1'b0}};
            ack_cnt1_q   <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            ack_cnt0_q   <= ack_cnt0_d;
            ack_cnt1_q   <= ack_cnt1_d;
        end
    end

    assign ack_cnt0 = ack_cnt0_q;
    assign ack_cnt1 = ack_cnt1_q;
endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a behavioural owner/counter
// model built from the arbitration rules.
module tb_wshb_arbiter;
    localparam int ADR_W = 32;
    localparam int DAT_W = 16;
    localparam int SEL_W = DAT_W / 8;
    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wshb_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) m0_if ();
    wshb_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) m1_if ();
    wshb_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) s_if ();

    logic [1:0]       grant;
    logic [CNT_W-1:0] ack_cnt0;
    logic [CNT_W-1:0] ack_cnt1;

    wshb_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .s        (s_if),
        .grant    (grant),
        .ack_cnt0 (ack_cnt0),
        .ack_cnt1 (ack_cnt1)
    );

    // stimulus state
    logic [1:0]       cyc_v, stb_v, we_v;
    logic [ADR_W-1:0] adr_v [2];
    logic [DAT_W-1:0] dat_v [2];
    logic [SEL_W-1:0] sel_v [2];
    logic             sack_v;
    logic [DAT_W-1:0] sdat_v;

    // reference model: owner -1 = nobody
    int owner, last, cnt0, cnt1;
    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = 1;
        cnt0  = 0;
        cnt1  = 0;
    endtask

    function automatic logic exp_ack(input int x);
        return sack_v && (owner == x) && cyc_v[x] && stb_v[x];
    endfunction

    task automatic drive();
        m0_if.cyc = cyc_v[0]; m0_if.stb = stb_v[0]; m0_if.we = we_v[0];
        m0_if.adr = adr_v[0]; m0_if.dat_ms = dat_v[0]; m0_if.sel = sel_v[0];
        m1_if.cyc = cyc_v[1]; m1_if.stb = stb_v[1]; m1_if.we = we_v[1];
        m1_if.adr = adr_v[1]; m1_if.dat_ms = dat_v[1]; m1_if.sel = sel_v[1];
        s_if.ack = sack_v;
        s_if.dat_sm = sdat_v;
    endtask

    task automatic check_outputs();
        logic [1:0]       eg;
        logic             ec, es, ew;
        logic [ADR_W-1:0] ea;
        logic [DAT_W-1:0] ed;
        logic [SEL_W-1:0] esl;
        eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        ec = 1'b0; es = 1'b0; ew = 1'b0; ea = '0; ed = '0; esl = '0;
        if (owner >= 0 && cyc_v[owner]) begin
            ec = 1'b1; es = stb_v[owner]; ew = we_v[owner];
            ea = adr_v[owner]; ed = dat_v[owner]; esl = sel_v[owner];
        end
        check_eq("grant", 64'(grant), 64'(eg));
        check_eq("s_cyc", 64'(s_if.cyc), 64'(ec));
        check_eq("s_stb", 64'(s_if.stb), 64'(es));
        check_eq("s_we", 64'(s_if.we), 64'(ew));
        check_eq("s_adr", 64'(s_if.adr), 64'(ea));
        check_eq("s_dat_ms", 64'(s_if.dat_ms), 64'(ed));
        check_eq("s_sel", 64'(s_if.sel), 64'(esl));
        check_eq("m0_ack", 64'(m0_if.ack), 64'(exp_ack(0)));
        check_eq("m1_ack", 64'(m1_if.ack), 64'(exp_ack(1)));
        check_eq("m0_dat_sm", 64'(m0_if.dat_sm), 64'(sdat_v));
        check_eq("m1_dat_sm", 64'(m1_if.dat_sm), 64'(sdat_v));
        check_eq("ack_cnt0", 64'(ack_cnt0), 64'(cnt0));
        check_eq("ack_cnt1", 64'(ack_cnt1), 64'(cnt1));
    endtask

    task automatic model_edge();
        if (exp_ack(0)) cnt0 = (cnt0 + 1) % CNT_MOD;
        if (exp_ack(1)) cnt1 = (cnt1 + 1) % CNT_MOD;
        if (owner < 0) begin
            if (cyc_v == 2'b11) begin
`ifdef WSHB_ARB_RR_EN
                owner = (last == 0) ? 1 : 0;
`else
                owner = 0;
`endif
            end else if (cyc_v[0]) owner = 0;
            else if (cyc_v[1]) owner = 1;
        end else if (!cyc_v[owner]) begin
            last  = owner;
            owner = cyc_v[1 - owner] ? 1 - owner : -1;
        end
    endtask

    // one clock: drive, check settled outputs, take the edge, update model
    task automatic step();
        drive();
        #2;
        check_outputs();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        cyc_v = 2'b00; stb_v = 2'b00; we_v = 2'b00; sack_v = 1'b0; sdat_v = '0;
        for (int i = 0; i < 2; i++) begin
            adr_v[i] = '0; dat_v[i] = '0; sel_v[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_s_cyc", 64'(s_if.cyc), 64'd0);
        check_eq("rst_cnt0", 64'(ack_cnt0), 64'd0);
        check_eq("rst_cnt1", 64'(ack_cnt1), 64'd0);
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic randomize_inputs();
        for (int x = 0; x < 2; x++) begin
            if ($urandom_range(0, 5) == 0) cyc_v[x] = ~cyc_v[x];
            stb_v[x] = ($urandom_range(0, 3) != 0);
            we_v[x]  = $urandom_range(0, 1) == 1;
            adr_v[x] = $urandom;
            dat_v[x] = DAT_W'($urandom);
            sel_v[x] = SEL_W'($urandom);
        end
        sack_v = $urandom_range(0, 1) == 1;
        sdat_v = DAT_W'($urandom);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        drive();
        @(posedge clk); #1;
        do_reset();

        // single M0 read, slave answers three cycles after stb
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; adr_v[0] = 32'h0000_1000; sel_v[0] = 2'b11;
        step();
        check_eq("t2_grant", 64'(grant), 64'd1);
        step(); step();
        sack_v = 1'b1; sdat_v = 16'hA5A5;
        drive(); #1;
        check_eq("t2_dat", 64'(m0_if.dat_sm), 64'hA5A5);
        check_eq("t2_ack", 64'(m0_if.ack), 64'd1);
        step();
        idle_inputs();
        step();
        check_eq("t2_cnt0", 64'(ack_cnt0), 64'd1);
        step();

        // both request together, four acks each, direct hand-over
        do_reset();
        cyc_v = 2'b11; stb_v = 2'b11;
        step();
        check_eq("t3_first", 64'(grant), 64'd1);
        sack_v = 1'b1;
        repeat (4) step();
        cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
        step();
        check_eq("t3_handover", 64'(grant), 64'd2);
        repeat (4) step();
        idle_inputs();
        step();
        check_eq("t3_cnt0", 64'(ack_cnt0), 64'd4);
        check_eq("t3_cnt1", 64'(ack_cnt1), 64'd4);
        step();

        // four repeated ties (last exit was M1)
        for (int r = 0; r < 4; r++) begin
            cyc_v = 2'b11; stb_v = 2'b11;
            step();
`ifdef WSHB_ARB_RR_EN
            check_eq("t4_tie", 64'(grant), (r % 2 == 0) ? 64'd1 : 64'd2);
`else
            check_eq("t4_tie", 64'(grant), 64'd1);
`endif
            step();
            cyc_v = 2'b00; stb_v = 2'b00;
            step();
        end
        step();

        // M1 aborts before the ack; late ack must not reach it
        cyc_v = 2'b10; stb_v = 2'b10;
        step();
        cyc_v = 2'b11; stb_v = 2'b11;
        step();
        check_eq("t5_own1", 64'(grant), 64'd2);
        cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
        step();
        check_eq("t5_m0_next", 64'(grant), 64'd1);
        stb_v[0] = 1'b0; sack_v = 1'b1;
        step();
        check_eq("t5_m1_ack", 64'(m1_if.ack), 64'd0);
        check_eq("t5_cnt1", 64'(ack_cnt1), 64'(cnt1));
        idle_inputs();
        step(); step();

        // 17 M1 acks wrap a 4-bit counter to 1
        do_reset();
        cyc_v = 2'b10; stb_v = 2'b10; sack_v = 1'b1;
        repeat (18) step();
        check_eq("t6_wrap", 64'(ack_cnt1), 64'd1);
        check_eq("t6_cnt0", 64'(ack_cnt0), 64'd0);
        idle_inputs();
        step();

        // random traffic with a mid-run reset
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            if (n == 1500) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
